// File: rtl/multiplier_fp_pkg.sv
// Shared types and constants for the binary32 multi-cycle multiplier.
package multiplier_fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    // Internal exponent width: signed, wide enough for ea + eb - bias plus two increments
    localparam int unsigned EXPI_W = 10;

    localparam logic signed [EXPI_W-1:0] MFP_BIAS    = 10'sd127;
    localparam logic signed [EXPI_W-1:0] MFP_EXP_MAX = 10'sd255;
    localparam logic [31:0]              MFP_QNAN    = 32'h7FC00000;
    localparam logic [30:0]              MFP_INF     = 31'h7F800000;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMult,
        StNorm,
        StRound,
        StDone
    } mfp_state_t;

    // Result class decided once at unpack time, carried through the pipeline
    typedef enum logic [1:0] {
        SpNormal,
        SpNan,
        SpInf,
        SpZero
    } mfp_special_t;

endpackage

// File: rtl/multiplier_fp_classify.sv
// Combinational binary32 operand classifier and unpacker.
// Subnormals are reported as zero and unpack to a zero mantissa.
module multiplier_fp_classify
    import multiplier_fp_pkg::*;
(
    input  logic [31:0]       operand_i,
    output logic              is_zero_o,
    output logic              is_inf_o,
    output logic              is_nan_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic              exp_all1;

    // Decode the exponent/fraction fields into class bits and a hidden-1 mantissa
    always_comb begin
        exp_f     = operand_i[30:23];
        frac_f    = operand_i[22:0];
        exp_all1  = (exp_f == {EXP_W{1'b1}});
        is_nan_o  = exp_all1 && (frac_f != '0);
        is_inf_o  = exp_all1 && (frac_f == '0);
        is_zero_o = (exp_f == '0);
        exp_o     = exp_f;
        mant_o    = is_zero_o ? '0 : {1'b1, frac_f};
    end

endmodule

// File: rtl/multiplier_fp.sv
// Multi-cycle IEEE 754 binary32 multiplier with start/done handshake.
// Build option: MULTIPLIER_FP_RNE_EN selects round-to-nearest-even; otherwise the
// result is truncated toward zero.
// Note: rst_n is an asynchronous, active-high reset despite its name.
module multiplier_fp
    import multiplier_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] product_o,
    output logic        done_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    mfp_state_t               state_q;
    logic [31:0]              a_q, b_q;
    logic                     sign_q;
    mfp_special_t             special_q, special_d;
    logic signed [EXPI_W-1:0] exp_q, exp_sum_d, exp_norm_d, exp_rnd;
    logic [MANT_W-1:0]        ma_q, mb_q;
    logic [PROD_W-1:0]        prod_q, prod_d;
    logic [FRAC_W-1:0]        frac_q, frac_d, frac_rnd;
    logic                     guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
    logic                     round_up, carry;
    logic [31:0]              product_q, product_d;
    logic                     done_q, nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d, unf_q, unf_d;

    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;

    multiplier_fp_classify u_classify_a (
        .operand_i (a_q),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan),
        .exp_o     (a_exp),
        .mant_o    (a_mant)
    );

    multiplier_fp_classify u_classify_b (
        .operand_i (b_q),
        .is_zero_o (b_zero),
        .is_inf_o  (b_inf),
        .is_nan_o  (b_nan),
        .exp_o     (b_exp),
        .mant_o    (b_mant)
    );

    // Unpack/multiply stages: special-case priority, biased exponent sum, raw product
    always_comb begin
        special_d = SpNormal;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_d = SpNan;
        end else if (a_inf || b_inf) begin
            special_d = SpInf;
        end else if (a_zero || b_zero) begin
            special_d = SpZero;
        end
        exp_sum_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - MFP_BIAS;
        prod_d    = {{MANT_W{1'b0}}, ma_q} * {{MANT_W{1'b0}}, mb_q};
    end

    // Normalize stage: a product in [2,4) is shifted right by one and the exponent bumped
    always_comb begin
        exp_norm_d = exp_q;
        if (prod_q[PROD_W-1]) begin
            frac_d     = prod_q[46:24];
            guard_d    = prod_q[23];
            rnd_d      = prod_q[22];
            sticky_d   = |prod_q[21:0];
            exp_norm_d = exp_q + 10'sd1;
        end else begin
            frac_d     = prod_q[45:23];
            guard_d    = prod_q[22];
            rnd_d      = prod_q[21];
            sticky_d   = |prod_q[20:0];
        end
    end

`ifndef MULTIPLIER_FP_RNE_EN
    // Guard/round/sticky only feed the rounding decision in the RNE build
    logic unused_grs;
    assign unused_grs = ^{guard_q, rnd_q, sticky_q};
`endif

    // Round stage and final result/flag selection
    always_comb begin
        round_up = 1'b0;
`ifdef MULTIPLIER_FP_RNE_EN
        round_up = guard_q & (rnd_q | sticky_q | frac_q[0]);
`endif
        // A carry out of the fraction means the mantissa rolled over to 2.0: 1.0 x 2^(e+1)
        {carry, frac_rnd} = {1'b0, frac_q} + {{FRAC_W{1'b0}}, round_up};
        exp_rnd = exp_q + {{(EXPI_W-1){1'b0}}, carry};

        product_d = 32'd0;
        nan_d     = 1'b0;
        inf_d     = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        case (special_q)
            SpNan: begin
                product_d = MFP_QNAN;
                nan_d     = 1'b1;
            end
            SpInf: begin
                product_d = {sign_q, MFP_INF};
                inf_d     = 1'b1;
            end
            SpZero: begin
                product_d = {sign_q, 31'd0};
            end
            default: begin
                if (exp_rnd >= MFP_EXP_MAX) begin
                    product_d = {sign_q, MFP_INF};
                    ovf_d     = 1'b1;
                end else if (exp_rnd <= 10'sd0) begin
                    product_d = {sign_q, 31'd0};
                    unf_d     = 1'b1;
                end else begin
                    product_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
                end
            end
        endcase
    end

    // Control FSM plus per-stage datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            special_q <= SpNormal;
            exp_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            prod_q    <= '0;
            frac_q    <= '0;
            guard_q   <= 1'b0;
            rnd_q     <= 1'b0;
            sticky_q  <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        state_q <= StUnpack;
                    end
                end
                StUnpack: begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    special_q <= special_d;
                    exp_q     <= exp_sum_d;
                    ma_q      <= a_mant;
                    mb_q      <= b_mant;
                    state_q   <= StMult;
                end
                StMult: begin
                    prod_q  <= prod_d;
                    state_q <= StNorm;
                end
                StNorm: begin
                    frac_q   <= frac_d;
                    guard_q  <= guard_d;
                    rnd_q    <= rnd_d;
                    sticky_q <= sticky_d;
                    exp_q    <= exp_norm_d;
                    state_q  <= StRound;
                end
                StRound: begin
                    product_q <= product_d;
                    nan_q     <= nan_d;
                    inf_q     <= inf_d;
                    ovf_q     <= ovf_d;
                    unf_q     <= unf_d;
                    done_q    <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign product_o   = product_q;
    assign done_o      = done_q;
    assign nan_o       = nan_q;
    assign infinit_o   = inf_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_multiplier_fp.sv
// Scoreboard bench for multiplier_fp: expectations are queued at launch and
// checked when done_o pulses. Tie-rounding expectation follows MULTIPLIER_FP_RNE_EN.
module tb_multiplier_fp;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_NAN  = 4'b1000;
    localparam logic [3:0] F_INF  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic [31:0] product_o;
    logic        done_o, nan_o, infinit_o, overflow_o, underflow_o;

    typedef struct {
        string       tag;
        logic [31:0] prod;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    multiplier_fp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .product_o   (product_o),
        .done_o      (done_o),
        .nan_o       (nan_o),
        .infinit_o   (infinit_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            check_eq("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_prod"}, product_o, e.prod);
                check_eq({e.tag, "_flags"},
                         {28'd0, nan_o, infinit_o, overflow_o, underflow_o},
                         {28'd0, e.flags});
            end
        end
    end

    // Pulse start for one cycle; returns at the negedge after the capture edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    // Wait (bounded) for done; lat0 is the number of edges already elapsed since capture
    task automatic wait_done(input string tag, input int lat0);
        int lat;
        lat = lat0;
        while (done_o !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
        check_eq({tag, "_latency"}, lat, 32'd4);
        @(negedge clk);
        check_eq({tag, "_done_width"}, {31'd0, done_o}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prod, input logic [3:0] flags);
        exp_t e;
        e.tag   = tag;
        e.prod  = prod;
        e.flags = flags;
        sb.push_back(e);
        launch(a, b);
        wait_done(tag, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_prod", product_o, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_flags", {28'd0, nan_o, infinit_o, overflow_o, underflow_o}, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_done", {31'd0, done_o}, 32'd0);

        run_op("mul_2p5x4",   32'h40200000, 32'h40800000, 32'h41200000, F_NONE);
        run_op("neg1x2",      32'hBF800000, 32'h40000000, 32'hC0000000, F_NONE);
        run_op("neg1p5x2",    32'hBFC00000, 32'h40000000, 32'hC0400000, F_NONE);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, F_NAN);
        run_op("ninf_x2",     32'hFF800000, 32'h40000000, 32'hFF800000, F_INF);
        run_op("zero_x_n3",   32'h00000000, 32'hC0400000, 32'h80000000, F_NONE);
        run_op("nan_in",      32'hFFC00000, 32'hBF800000, 32'h7FC00000, F_NAN);
        run_op("subn_x2",     32'h00000001, 32'h40000000, 32'h00000000, F_NONE);
        run_op("nsubn_x_inf", 32'h80000001, 32'h7F800000, 32'h7FC00000, F_NAN);
        run_op("overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, F_OVF);
        run_op("neg_ovf",     32'hFF000000, 32'h40000000, 32'hFF800000, F_OVF);
        run_op("max_normal",  32'h7F000000, 32'h3F800000, 32'h7F000000, F_NONE);
        run_op("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, F_UNF);
        run_op("min_normal",  32'h00800000, 32'h3F800000, 32'h00800000, F_NONE);
        run_op("rnd_small",   32'h3F800001, 32'h3F800001, 32'h3F800002, F_NONE);
        run_op("rnd_max",     32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, F_NONE);
`ifdef MULTIPLIER_FP_RNE_EN
        run_op("rnd_tie",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, F_NONE);
`else
        run_op("rnd_tie",     32'h3F800001, 32'h3FC00000, 32'h3FC00001, F_NONE);
`endif

        // start pulsed while in MULT must be ignored; operands also change after capture
        begin
            exp_t e;
            e.tag   = "ign_start";
            e.prod  = 32'h41200000;
            e.flags = F_NONE;
            sb.push_back(e);
            launch(32'h40200000, 32'h40800000);
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b1;
            a_i     = 32'h3F800000;
            b_i     = 32'h3F800000;
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            wait_done("ign_start", 2);
            extra = 0;
            repeat (10) begin
                @(negedge clk);
                if (done_o === 1'b1) extra++;
            end
            check_eq("ign_start_no_extra", extra, 32'd0);
        end

        // Reset while in NORM aborts the operation and clears the outputs
        launch(32'hBFC00000, 32'h40000000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("abort_prod", product_o, 32'd0);
        check_eq("abort_done", {31'd0, done_o}, 32'd0);
        check_eq("abort_flags", {28'd0, nan_o, infinit_o, overflow_o, underflow_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o === 1'b1) extra++;
        end
        check_eq("abort_no_done", extra, 32'd0);

        run_op("after_abort", 32'h40400000, 32'h40400000, 32'h41100000, F_NONE);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
